// File: rtl/div_result_bcd.sv
// Result stage after the restoring divider: captures quotient/remainder, converts
// each to two BCD digits with double dabble (one bit per clock), hands off via Valid/Ack.
module div_result_bcd #(
  parameter int unsigned N = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         Start,
  input  logic [N-1:0] Quotient,
  input  logic [N-1:0] Remainder,
  input  logic         DivZero,
  input  logic         Ack,
  output logic         Busy,
  output logic         Valid,
  output logic         Err,
  output logic [3:0]   Q_Tens,
  output logic [3:0]   Q_Ones,
  output logic [3:0]   R_Tens,
  output logic [3:0]   R_Ones
);

  localparam int unsigned SW = N + 8;
  localparam int unsigned CW = $clog2(N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [SW-1:0] q_sr, q_sr_nxt;
  logic [SW-1:0] r_sr, r_sr_nxt;
  logic          busy_nxt, valid_nxt, err_nxt;
  logic [3:0]    q_tens_nxt, q_ones_nxt, r_tens_nxt, r_ones_nxt;

  // One double-dabble step on {tens, ones, binary}: add 3 to nibbles >= 5, then shift left.
  function automatic logic [SW-1:0] dd_step(input logic [SW-1:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = v[SW-1 -: 4];
    ones = v[N+3 -: 4];
    if (tens >= 4'd5) tens = tens + 4'd3;
    if (ones >= 4'd5) ones = ones + 4'd3;
    return {tens, ones, v[N-1:0]} << 1;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Divide-by-zero enters CONV with a zero count so both paths share the DONE-entry cycle.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    q_sr_nxt   = q_sr;
    r_sr_nxt   = r_sr;
    busy_nxt   = 1'b0;
    valid_nxt  = 1'b0;
    err_nxt    = Err;
    q_tens_nxt = Q_Tens;
    q_ones_nxt = Q_Ones;
    r_tens_nxt = R_Tens;
    r_ones_nxt = R_Ones;
    unique case (state)
      IDLE: begin
        if (Start) begin
          state_nxt = CONV;
          q_sr_nxt  = {8'd0, Quotient};
          r_sr_nxt  = {8'd0, Remainder};
          cnt_nxt   = DivZero ? '0 : CW'(N);
          err_nxt   = DivZero;
          busy_nxt  = ~DivZero;
        end
      end
      CONV: begin
        if (cnt != '0) begin
          q_sr_nxt = dd_step(q_sr);
          r_sr_nxt = dd_step(r_sr);
          cnt_nxt  = cnt - CW'(1);
          busy_nxt = (cnt != CW'(1));
        end else begin
          state_nxt  = DONE;
          valid_nxt  = 1'b1;
          q_tens_nxt = q_sr[SW-1 -: 4];
          q_ones_nxt = q_sr[N+3 -: 4];
          r_tens_nxt = r_sr[SW-1 -: 4];
          r_ones_nxt = r_sr[N+3 -: 4];
        end
      end
      DONE: begin
        valid_nxt = 1'b1;
        if (Ack) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt    <= '0;
      q_sr   <= '0;
      r_sr   <= '0;
      Busy   <= 1'b0;
      Valid  <= 1'b0;
      Err    <= 1'b0;
      Q_Tens <= 4'd0;
      Q_Ones <= 4'd0;
      R_Tens <= 4'd0;
      R_Ones <= 4'd0;
    end else begin
      cnt    <= cnt_nxt;
      q_sr   <= q_sr_nxt;
      r_sr   <= r_sr_nxt;
      Busy   <= busy_nxt;
      Valid  <= valid_nxt;
      Err    <= err_nxt;
      Q_Tens <= q_tens_nxt;
      Q_Ones <= q_ones_nxt;
      R_Tens <= r_tens_nxt;
      R_Ones <= r_ones_nxt;
    end
  end

endmodule

// File: tb/tb_div_result_bcd.sv
// Scoreboard bench for div_result_bcd: expected digits queued at Start, checked at Valid.
module tb_div_result_bcd;

  localparam int unsigned N = 4;

  typedef struct packed {
    logic        err;
    logic [3:0]  qt;
    logic [3:0]  qo;
    logic [3:0]  rt;
    logic [3:0]  ro;
    logic [31:0] lat;
  } exp_t;

  logic         CLK;
  logic         RST;
  logic         Start;
  logic [N-1:0] Quotient;
  logic [N-1:0] Remainder;
  logic         DivZero;
  logic         Ack;
  logic         Busy;
  logic         Valid;
  logic         Err;
  logic [3:0]   Q_Tens, Q_Ones, R_Tens, R_Ones;

  exp_t sb[$];
  exp_t last_exp;
  exp_t dropped;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  div_result_bcd #(.N(N)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Quotient(Quotient), .Remainder(Remainder),
    .DivZero(DivZero), .Ack(Ack), .Busy(Busy), .Valid(Valid), .Err(Err),
    .Q_Tens(Q_Tens), .Q_Ones(Q_Ones), .R_Tens(R_Tens), .R_Ones(R_Ones)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] q, input logic [N-1:0] r, input logic dz);
    exp_t e;
    int   qi;
    int   ri;
    qi = int'(q);
    ri = int'(r);
    e.err = dz;
    e.qt  = dz ? 4'd0 : 4'(qi / 10);
    e.qo  = dz ? 4'd0 : 4'(qi % 10);
    e.rt  = dz ? 4'd0 : 4'(ri / 10);
    e.ro  = dz ? 4'd0 : 4'(ri % 10);
    e.lat = dz ? 32'd1 : 32'(N + 1);
    return e;
  endfunction

  function automatic logic [31:0] digits();
    return 32'({Err, Q_Tens, Q_Ones, R_Tens, R_Ones});
  endfunction

  function automatic logic [31:0] exp_digits(input exp_t e);
    return 32'({e.err, e.qt, e.qo, e.rt, e.ro});
  endfunction

  function automatic logic [31:0] all_outs();
    return 32'({Busy, Valid, Err, Q_Tens, Q_Ones, R_Tens, R_Ones});
  endfunction

  // Capture one result and wait for Valid; optionally pulse Start mid-conversion.
  task automatic run_op(input string tag, input logic [N-1:0] q, input logic [N-1:0] r,
                        input logic dz, input bit pulse_conv);
    exp_t e;
    int   busy_cnt;
    int   start_cyc;
    bit   seen;
    @(negedge CLK);
    Quotient  = q;
    Remainder = r;
    DivZero   = dz;
    Start     = 1'b1;
    start_cyc = cyc + 1;
    sb.push_back(model(q, r, dz));
    busy_cnt = 0;
    seen     = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (Busy)  busy_cnt++;
      if (Valid) seen = 1'b1;
      Start     = pulse_conv && (i == 1);
      Quotient  = N'($urandom);
      Remainder = N'($urandom);
      DivZero   = 1'b0;
    end
    Start = 1'b0;
    if (!seen) begin
      check({tag, " timeout"}, 32'(Valid), 32'd1);
      if (sb.size() > 0) dropped = sb.pop_front();
    end else begin
      e = sb.pop_front();
      check({tag, " latency"}, 32'(cyc - start_cyc), e.lat);
      check({tag, " digits"}, digits(), exp_digits(e));
      check({tag, " busy_cycles"}, 32'(busy_cnt), dz ? 32'd0 : 32'(N));
      last_exp = e;
    end
  endtask

  // Result must hold while unacknowledged; Valid drops the cycle after Ack, digits stay.
  task automatic ack_done(input string tag);
    repeat (2) @(negedge CLK);
    check({tag, " hold"}, all_outs(), 32'({2'b01, 17'(exp_digits(last_exp))}));
    Ack = 1'b1;
    @(negedge CLK);
    Ack = 1'b0;
    check({tag, " after_ack"}, all_outs(), 32'({2'b00, 17'(exp_digits(last_exp))}));
  endtask

  initial begin
    RST = 1'b1; Start = 1'b0; Ack = 1'b0; DivZero = 1'b0;
    Quotient = '0; Remainder = '0;
    repeat (3) @(negedge CLK);
    check("reset_outs", all_outs(), 32'd0);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check("idle_outs", all_outs(), 32'd0);

    run_op("q13_r2", 4'd13, 4'd2, 1'b0, 1'b0);
    ack_done("q13_r2");
    run_op("q15_r10", 4'd15, 4'd10, 1'b0, 1'b0);
    ack_done("q15_r10");
    run_op("q0_r9", 4'd0, 4'd9, 1'b0, 1'b0);
    ack_done("q0_r9");
    run_op("divzero", 4'd15, 4'd3, 1'b1, 1'b0);
    ack_done("divzero");
    run_op("start_in_conv", 4'd6, 4'd4, 1'b0, 1'b1);

    // Start while in DONE is dropped.
    @(negedge CLK);
    Start = 1'b1; Quotient = 4'd1; Remainder = 4'd1;
    @(negedge CLK);
    Start = 1'b0;
    @(negedge CLK);
    check("start_in_done", all_outs(), 32'({2'b01, 17'(exp_digits(last_exp))}));
    ack_done("start_in_done");

    run_op("q11_r12", 4'd11, 4'd12, 1'b0, 1'b0);
    // Start with Ack in DONE: return to IDLE without a new capture.
    @(negedge CLK);
    Start = 1'b1; Ack = 1'b1; Quotient = 4'd9; Remainder = 4'd9;
    @(negedge CLK);
    Start = 1'b0; Ack = 1'b0;
    repeat (3) @(negedge CLK);
    check("start_ack_done", all_outs(), 32'({2'b00, 17'(exp_digits(last_exp))}));

    // Ack in IDLE has no effect.
    Ack = 1'b1;
    @(negedge CLK);
    Ack = 1'b0;
    @(negedge CLK);
    check("ack_in_idle", all_outs(), 32'({2'b00, 17'(exp_digits(last_exp))}));

    for (int i = 0; i < 6; i++) begin
      run_op("random", N'($urandom), N'($urandom), 1'b0, 1'b0);
      ack_done("random");
    end

    // Reset during the second CONV cycle aborts immediately.
    @(negedge CLK);
    Start = 1'b1; Quotient = 4'd5; Remainder = 4'd5; DivZero = 1'b0;
    sb.push_back(model(4'd5, 4'd5, 1'b0));
    @(negedge CLK);
    Start = 1'b0;
    @(posedge CLK);
    #2 RST = 1'b1;
    #1 check("async_reset", all_outs(), 32'd0);
    dropped = sb.pop_back();
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("post_reset_idle", all_outs(), 32'd0);
    run_op("q7_r3", 4'd7, 4'd3, 1'b0, 1'b0);
    ack_done("q7_r3");

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
